// File: rtl/kob_mc.sv
// kob_mc -- parametrised multi-channel key-order buffer.
// For every channel, records the bank ID of each accepted load in program
// order and presents the oldest outstanding bank ID downstream through a
// req/ack handshake. Channels are fully independent.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   u_req_valid      per-channel upstream request valid
//   u_req_ready      per-channel upstream request ready (observed only)
//   u_req_is_load    per-channel "request is a load"
//   u_req_addr       per-channel address, channel c at [c*ADDR_W +: ADDR_W]
//   flush            per-channel synchronous flush
//   d_rob_req        per-channel "oldest entry valid"
//   d_rob_ack        per-channel downstream accept of the oldest entry
//   d_rob_bank_id    per-channel bank ID of the oldest entry
//   kob_full         channel holds DEPTH entries
//   kob_afull        channel count >= AFULL_THR
//   kob_empty        channel holds no entries
//   kob_count        per-channel occupancy, CNT_W bits each
//   ovf_err          sticky: a load arrived while the channel was full
module kob_mc #(
    parameter int NUM_CH    = 3,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 32,
    parameter int BANK_W    = 2,
    parameter int BANK_LSB  = 8,
    parameter int AFULL_THR = 6,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          u_req_valid,
    input  logic [NUM_CH-1:0]          u_req_ready,
    input  logic [NUM_CH-1:0]          u_req_is_load,
    input  logic [NUM_CH*ADDR_W-1:0]   u_req_addr,
    input  logic [NUM_CH-1:0]          flush,
    output logic [NUM_CH-1:0]          d_rob_req,
    input  logic [NUM_CH-1:0]          d_rob_ack,
    output logic [NUM_CH*BANK_W-1:0]   d_rob_bank_id,
    output logic [NUM_CH-1:0]          kob_full,
    output logic [NUM_CH-1:0]          kob_afull,
    output logic [NUM_CH-1:0]          kob_empty,
    output logic [NUM_CH*CNT_W-1:0]    kob_count,
    output logic [NUM_CH-1:0]          ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);

    // Only the bank field of each address is stored; fold the rest away.
    logic unused_addr_s;
    assign unused_addr_s = ^u_req_addr;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [PTR_W-1:0]  alloc_ptr_q, alloc_ptr_d, ret_ptr_q, ret_ptr_d;
            logic              alloc_wrap_q, alloc_wrap_d, ret_wrap_q, ret_wrap_d;
            logic [DEPTH-1:0]  valid_q, valid_d;
            logic [BANK_W-1:0] bank_q [DEPTH];
            logic [BANK_W-1:0] bank_d [DEPTH];
            logic [CNT_W-1:0]  count_q, count_d;
            logic              ovf_q, ovf_d;
            logic              req_q, req_d;
            logic [BANK_W-1:0] bank_id_q, bank_id_d;
            logic              full_q, full_d, empty_q, empty_d, afull_q, afull_d;
            logic              wr_s, wr_ok_s, rt_s;
            logic [BANK_W-1:0] wr_bank_s;

            assign wr_bank_s = u_req_addr[c*ADDR_W + BANK_LSB +: BANK_W];
            assign wr_s      = u_req_valid[c] & u_req_ready[c] & u_req_is_load[c];
            // full_q is registered, so a retire in the same cycle cannot
            // make room for a write that arrives while full.
            assign wr_ok_s   = wr_s & ~full_q;
            // Acks are only meaningful while an entry is presented.
            assign rt_s      = req_q & d_rob_ack[c];

            // Next-state for pointers, entries, count, overflow and flags.
            always_comb begin
                alloc_ptr_d  = alloc_ptr_q;
                alloc_wrap_d = alloc_wrap_q;
                ret_ptr_d    = ret_ptr_q;
                ret_wrap_d   = ret_wrap_q;
                valid_d      = valid_q;
                bank_d       = bank_q;
                count_d      = count_q;
                ovf_d        = ovf_q;
                if (flush[c]) begin
                    // Bank data is left alone: invalid entries are don't-care.
                    alloc_ptr_d  = {PTR_W{1'b0}};
                    alloc_wrap_d = 1'b0;
                    ret_ptr_d    = {PTR_W{1'b0}};
                    ret_wrap_d   = 1'b0;
                    valid_d      = {DEPTH{1'b0}};
                    count_d      = {CNT_W{1'b0}};
                    ovf_d        = 1'b0;
                end else begin
                    if (wr_ok_s) begin
                        valid_d[alloc_ptr_q] = 1'b1;
                        bank_d[alloc_ptr_q]  = wr_bank_s;
                        alloc_ptr_d          = alloc_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
                        if (alloc_ptr_q == {PTR_W{1'b1}}) begin
                            alloc_wrap_d = ~alloc_wrap_q;
                        end else begin
                            alloc_wrap_d = alloc_wrap_q;
                        end
                    end else begin
                        alloc_ptr_d = alloc_ptr_q;
                    end
                    if (wr_s && full_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    if (rt_s) begin
                        valid_d[ret_ptr_q] = 1'b0;
                        ret_ptr_d          = ret_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
                        if (ret_ptr_q == {PTR_W{1'b1}}) begin
                            ret_wrap_d = ~ret_wrap_q;
                        end else begin
                            ret_wrap_d = ret_wrap_q;
                        end
                    end else begin
                        ret_ptr_d = ret_ptr_q;
                    end
                    case ({wr_ok_s, rt_s})
                        2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                        default: count_d = count_q;
                    endcase
                end
                // Outputs are precomputed from next state so they leave flops.
                req_d     = valid_d[ret_ptr_d];
                bank_id_d = bank_d[ret_ptr_d];
                empty_d   = (alloc_ptr_d == ret_ptr_d) && (alloc_wrap_d == ret_wrap_d);
                full_d    = (alloc_ptr_d == ret_ptr_d) && (alloc_wrap_d != ret_wrap_d);
                afull_d   = (count_d >= CNT_W'(AFULL_THR));
            end

            // Channel state registers with asynchronous reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    alloc_ptr_q  <= {PTR_W{1'b0}};
                    alloc_wrap_q <= 1'b0;
                    ret_ptr_q    <= {PTR_W{1'b0}};
                    ret_wrap_q   <= 1'b0;
                    valid_q      <= {DEPTH{1'b0}};
                    for (int i = 0; i < DEPTH; i++) begin
                        bank_q[i] <= {BANK_W{1'b0}};
                    end
                    count_q      <= {CNT_W{1'b0}};
                    ovf_q        <= 1'b0;
                    req_q        <= 1'b0;
                    bank_id_q    <= {BANK_W{1'b0}};
                    full_q       <= 1'b0;
                    empty_q      <= 1'b1;
                    afull_q      <= 1'b0;
                end else begin
                    alloc_ptr_q  <= alloc_ptr_d;
                    alloc_wrap_q <= alloc_wrap_d;
                    ret_ptr_q    <= ret_ptr_d;
                    ret_wrap_q   <= ret_wrap_d;
                    valid_q      <= valid_d;
                    bank_q       <= bank_d;
                    count_q      <= count_d;
                    ovf_q        <= ovf_d;
                    req_q        <= req_d;
                    bank_id_q    <= bank_id_d;
                    full_q       <= full_d;
                    empty_q      <= empty_d;
                    afull_q      <= afull_d;
                end
            end

            assign d_rob_req[c]                      = req_q;
            assign d_rob_bank_id[c*BANK_W +: BANK_W] = bank_id_q;
            assign kob_full[c]                       = full_q;
            assign kob_afull[c]                      = afull_q;
            assign kob_empty[c]                      = empty_q;
            assign kob_count[c*CNT_W +: CNT_W]       = count_q;
            assign ovf_err[c]                        = ovf_q;
        end
    endgenerate

endmodule

// File: tb/tb_kob_mc.sv
// Directed testbench for kob_mc (NUM_CH=3, DEPTH=8, default parameters).
module tb_kob_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  u_req_valid, u_req_ready, u_req_is_load, flush, d_rob_ack;
    logic [95:0] u_req_addr;
    logic [2:0]  d_rob_req, kob_full, kob_afull, kob_empty, ovf_err;
    logic [5:0]  d_rob_bank_id;
    logic [11:0] kob_count;

    int checks = 0;
    int errors = 0;

    kob_mc dut (
        .clk(clk), .rst(rst),
        .u_req_valid(u_req_valid), .u_req_ready(u_req_ready),
        .u_req_is_load(u_req_is_load), .u_req_addr(u_req_addr),
        .flush(flush), .d_rob_req(d_rob_req), .d_rob_ack(d_rob_ack),
        .d_rob_bank_id(d_rob_bank_id), .kob_full(kob_full),
        .kob_afull(kob_afull), .kob_empty(kob_empty),
        .kob_count(kob_count), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  vld;
        logic [2:0]  ld;
        logic [95:0] addr;
        logic [2:0]  ack;
        logic [2:0]  e_req;
        logic [5:0]  e_bank;
        logic [2:0]  e_full;
        logic [2:0]  e_afull;
        logic [2:0]  e_empty;
        logic [11:0] e_cnt;
        logic [2:0]  e_ovf;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(logic [2:0] vld, logic [2:0] ld, logic [95:0] addr,
                                logic [2:0] ack, logic [2:0] e_req, logic [5:0] e_bank,
                                logic [2:0] e_full, logic [2:0] e_afull,
                                logic [2:0] e_empty, logic [11:0] e_cnt, logic [2:0] e_ovf);
        vec_t v;
        v.vld = vld; v.ld = ld; v.addr = addr; v.ack = ack;
        v.e_req = e_req; v.e_bank = e_bank; v.e_full = e_full; v.e_afull = e_afull;
        v.e_empty = e_empty; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        u_req_valid = 3'b000; u_req_ready = 3'b000; u_req_is_load = 3'b000;
        u_req_addr = 96'h0; flush = 3'b000; d_rob_ack = 3'b000;
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write one load with the given bank to channel ch, optionally acking.
    task automatic drive_wr(input int ch, input logic [1:0] bank, input logic [2:0] ack);
        logic [95:0] a;
        a = 96'h0;
        a[ch*32 + 8 +: 2] = bank;
        u_req_valid[ch] = 1'b1; u_req_ready[ch] = 1'b1; u_req_is_load[ch] = 1'b1;
        u_req_addr = a;
        d_rob_ack = ack;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"}, 32'(kob_empty), 32'h7);
        chk({tag, "_count"}, 32'(kob_count), 32'h0);
        chk({tag, "_req"},   32'(d_rob_req), 32'h0);
        chk({tag, "_ovf"},   32'(ovf_err),   32'h0);
        chk({tag, "_full"},  32'(kob_full),  32'h0);
        chk({tag, "_afull"}, 32'(kob_afull), 32'h0);
        chk({tag, "_bank"},  32'(d_rob_bank_id), 32'h0);
    endtask

    initial begin
        logic [1:0] q2 [$];
        logic [5:0] mask;
        idle();
        rst = 1'b1;

        // Ch0: three loads (banks 1,2,3) then three acks.
        tbl[0]  = mk(3'b001, 3'b001, 96'h100, 3'b000, 3'b001, 6'b000001, 3'b000, 3'b000, 3'b110, 12'h001, 3'b000);
        tbl[1]  = mk(3'b001, 3'b001, 96'h200, 3'b000, 3'b001, 6'b000001, 3'b000, 3'b000, 3'b110, 12'h002, 3'b000);
        tbl[2]  = mk(3'b001, 3'b001, 96'h300, 3'b000, 3'b001, 6'b000001, 3'b000, 3'b000, 3'b110, 12'h003, 3'b000);
        tbl[3]  = mk(3'b000, 3'b000, 96'h0,   3'b001, 3'b001, 6'b000010, 3'b000, 3'b000, 3'b110, 12'h002, 3'b000);
        tbl[4]  = mk(3'b000, 3'b000, 96'h0,   3'b001, 3'b001, 6'b000011, 3'b000, 3'b000, 3'b110, 12'h001, 3'b000);
        tbl[5]  = mk(3'b000, 3'b000, 96'h0,   3'b001, 3'b000, 6'b000000, 3'b000, 3'b000, 3'b111, 12'h000, 3'b000);
        // Ch1: eight loads (banks 0,1,2,3,0,1,2,3), afull from 6, full at 8.
        tbl[6]  = mk(3'b010, 3'b010, 96'h0_00000000, 3'b000, 3'b010, 6'b0, 3'b000, 3'b000, 3'b101, 12'h010, 3'b000);
        tbl[7]  = mk(3'b010, 3'b010, 96'h1_00000000 << 8, 3'b000, 3'b010, 6'b0, 3'b000, 3'b000, 3'b101, 12'h020, 3'b000);
        tbl[8]  = mk(3'b010, 3'b010, 96'h2_00000000 << 8, 3'b000, 3'b010, 6'b0, 3'b000, 3'b000, 3'b101, 12'h030, 3'b000);
        tbl[9]  = mk(3'b010, 3'b010, 96'h3_00000000 << 8, 3'b000, 3'b010, 6'b0, 3'b000, 3'b000, 3'b101, 12'h040, 3'b000);
        tbl[10] = mk(3'b010, 3'b010, 96'h0_00000000, 3'b000, 3'b010, 6'b0, 3'b000, 3'b000, 3'b101, 12'h050, 3'b000);
        tbl[11] = mk(3'b010, 3'b010, 96'h1_00000000 << 8, 3'b000, 3'b010, 6'b0, 3'b000, 3'b010, 3'b101, 12'h060, 3'b000);
        tbl[12] = mk(3'b010, 3'b010, 96'h2_00000000 << 8, 3'b000, 3'b010, 6'b0, 3'b000, 3'b010, 3'b101, 12'h070, 3'b000);
        tbl[13] = mk(3'b010, 3'b010, 96'h3_00000000 << 8, 3'b000, 3'b010, 6'b0, 3'b010, 3'b010, 3'b101, 12'h080, 3'b000);
        // 9th write while full with simultaneous ack: dropped, overflow, count 7.
        tbl[14] = mk(3'b010, 3'b010, 96'h0_00000000, 3'b010, 3'b010, 6'b000100, 3'b000, 3'b010, 3'b101, 12'h070, 3'b010);
        // Store handshake on ch1 creates no entry.
        tbl[15] = mk(3'b010, 3'b000, 96'h3_00000000 << 8, 3'b000, 3'b010, 6'b000100, 3'b000, 3'b010, 3'b101, 12'h070, 3'b010);

        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;
        tick();
        chk("idle_req", 32'(d_rob_req), 32'h0);

        for (int i = 0; i < 16; i++) begin
            u_req_valid = tbl[i].vld; u_req_ready = tbl[i].vld;
            u_req_is_load = tbl[i].ld; u_req_addr = tbl[i].addr;
            d_rob_ack = tbl[i].ack; flush = 3'b000;
            tick();
            idle();
            mask = {{2{tbl[i].e_req[2]}}, {2{tbl[i].e_req[1]}}, {2{tbl[i].e_req[0]}}};
            chk($sformatf("v%0d_req", i),   32'(d_rob_req), 32'(tbl[i].e_req));
            chk($sformatf("v%0d_bank", i),  32'(d_rob_bank_id & mask), 32'(tbl[i].e_bank & mask));
            chk($sformatf("v%0d_full", i),  32'(kob_full),  32'(tbl[i].e_full));
            chk($sformatf("v%0d_afull", i), 32'(kob_afull), 32'(tbl[i].e_afull));
            chk($sformatf("v%0d_empty", i), 32'(kob_empty), 32'(tbl[i].e_empty));
            chk($sformatf("v%0d_count", i), 32'(kob_count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_ovf", i),   32'(ovf_err),   32'(tbl[i].e_ovf));
        end

        // Ch2: 20 writes, 19 with a simultaneous ack, across two pointer wraps.
        drive_wr(2, 2'd0, 3'b000);
        q2.push_back(2'd0);
        tick();
        idle();
        chk("ch2_first_req", 32'(d_rob_req[2]), 32'h1);
        chk("ch2_first_bank", 32'(d_rob_bank_id[5:4]), 32'(q2[0]));
        for (int i = 1; i < 20; i++) begin
            drive_wr(2, 2'(i % 4), 3'b100);
            q2.push_back(2'(i % 4));
            void'(q2.pop_front());
            tick();
            idle();
            chk($sformatf("ch2_cnt_%0d", i), 32'(kob_count[11:8]), 32'h1);
            chk($sformatf("ch2_bank_%0d", i), 32'(d_rob_bank_id[5:4]), 32'(q2[0]));
        end
        d_rob_ack = 3'b100;
        void'(q2.pop_front());
        tick();
        idle();
        chk("ch2_drain_cnt", 32'(kob_count[11:8]), 32'h0);
        chk("ch2_drain_empty", 32'(kob_empty[2]), 32'h1);
        chk("ch2_drain_req", 32'(d_rob_req[2]), 32'h0);

        // Ack on an empty channel is ignored.
        d_rob_ack = 3'b100;
        tick();
        idle();
        chk("ch2_ack_empty_cnt", 32'(kob_count[11:8]), 32'h0);

        // Ch0 holds 5 entries, then flush and a write in the same cycle.
        for (int i = 0; i < 5; i++) begin
            drive_wr(0, 2'(i % 4), 3'b000);
            tick();
            idle();
        end
        chk("ch0_five", 32'(kob_count[3:0]), 32'h5);
        drive_wr(0, 2'd3, 3'b000);
        flush = 3'b001;
        tick();
        idle();
        chk("flush_count", 32'(kob_count), 32'h070);
        chk("flush_empty", 32'(kob_empty), 32'h5);
        chk("flush_req",   32'(d_rob_req), 32'h2);
        chk("flush_ovf",   32'(ovf_err),   32'h2);
        chk("flush_afull", 32'(kob_afull), 32'h2);

        // Four entries held on ch0, then reset pulsed between clock edges.
        for (int i = 0; i < 4; i++) begin
            drive_wr(0, 2'd2, 3'b000);
            tick();
            idle();
        end
        chk("pre_rst_count", 32'(kob_count[3:0]), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("async_rst");
        rst = 1'b0;
        #1;
        chk_reset_state("post_rst");

        // Channel works again after reset.
        drive_wr(0, 2'd1, 3'b000);
        tick();
        idle();
        chk("restart_req",  32'(d_rob_req), 32'h1);
        chk("restart_bank", 32'(d_rob_bank_id[1:0]), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kob_mc.md
Name: kob_mc

Overview:
- Parametrised multi-channel key-order buffer: the next generation of the 3-channel, fixed-depth key-order buffer.
- For each upstream channel it records the bank ID of every accepted load request in program order. It presents the oldest outstanding bank ID to the downstream reorder buffer through a req/ack handshake.
- New in this generation: channel count, depth and bank-field position are parameters.
- New behaviour: per-channel occupancy count, almost-full flag, synchronous per-channel flush, and a sticky overflow error.

Parameters:
NUM_CH, 3, number of independent channels
DEPTH, 8, entries per channel; power of two, at least 2
ADDR_W, 32, request address width
BANK_W, 2, bank ID width
BANK_LSB, 8, LSB of the bank field in the address; bank_id = addr[BANK_LSB+BANK_W-1:BANK_LSB]
AFULL_THR, 6, count at or above which kob_afull asserts; range 1..DEPTH
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
u_req_valid  in  NUM_CH  upstream request valid, per channel
u_req_ready  in  NUM_CH  upstream request ready, per channel (observed only)
u_req_is_load  in  NUM_CH  request is a load
u_req_addr  in  NUM_CH*ADDR_W  request address; channel c occupies bits [c*ADDR_W +: ADDR_W]
flush  in  NUM_CH  synchronous per-channel flush
d_rob_req  out  NUM_CH  oldest entry valid
d_rob_ack  in  NUM_CH  downstream accepts the oldest entry
d_rob_bank_id  out  NUM_CH*BANK_W  bank ID of the oldest entry
kob_full  out  NUM_CH  channel holds DEPTH entries
kob_afull  out  NUM_CH  count >= AFULL_THR
kob_empty  out  NUM_CH  channel holds 0 entries
kob_count  out  NUM_CH*CNT_W  channel occupancy
ovf_err  out  NUM_CH  sticky overflow: a write arrived while the channel was full

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: all pointers, wrap flags, valid bits and counts are 0. d_rob_req=0, d_rob_bank_id=0, kob_full=0, kob_afull=0, kob_empty=1, kob_count=0, ovf_err=0.
- Channel independence: channels are fully independent; no cross-channel arbitration.
- Write event (channel c): wr = u_req_valid & u_req_ready & u_req_is_load.
  - If wr and not full, the bank ID is stored at alloc_ptr and the entry valid bit is set.
  - alloc_ptr increments modulo DEPTH; its wrap flag toggles when alloc_ptr goes DEPTH-1 -> 0.
- Retire event: rt = d_rob_req & d_rob_ack. The entry at ret_ptr is cleared and ret_ptr increments with the same wrap-flag rule.
- d_rob_req = valid[ret_ptr]; d_rob_bank_id = bank[ret_ptr]. Both come directly from registers; there is no combinational path from any input.
- Latency: a write is visible on d_rob_req in the cycle after the accepting edge. There is no empty bypass.
- Status flags:
  - Pointers equal and wrap flags equal means empty.
  - Pointers equal and wrap flags differ means full.
  - kob_full, kob_empty and kob_afull all derive from registered state.
- kob_count: +1 on accepted write only, -1 on retire only, unchanged when both occur in the same cycle. It is never below 0 or above DEPTH.
- Write while full: the entry is dropped, state is unchanged, and ovf_err[c] sets. This holds even if a retire occurs in the same cycle, because full is evaluated on the pre-edge state. Upstream must gate u_req_ready with kob_full.
- ovf_err clears only on rst or flush[c].
- Ack while d_rob_req=0 is ignored.
- Flush: flush[c] has priority over write and retire in the same cycle. On the next edge it sets both pointers and wrap flags to 0, clears all valid bits, sets count=0 and clears ovf_err. The next cycle shows kob_empty=1 and d_rob_req=0.
- Stored bank data is not cleared by flush; it is don't-care while the entry is invalid.
- Wrap-around: correct ordering is maintained across an unlimited number of pointer wraps.
- Reset asserted mid-operation: all state clears immediately (asynchronously) and outputs return to their reset values within the same cycle.

Test Plan:
- Reset, NUM_CH=3, DEPTH=8: kob_empty=3'b111, kob_count=0, d_rob_req=0, ovf_err=0.
- Ch0 writes loads with addr 0x100, 0x200, 0x300 in consecutive cycles, then acks each:
  - d_rob_bank_id[1:0] returns 1, 2, 3 in order.
  - d_rob_req rises 1 cycle after the first write.
  - kob_count peaks at 3 and returns to 0.
- Ch1 writes 8 loads: kob_full[1]=1; kob_afull[1]=1 from count 6. A 9th write with a simultaneous ack: the entry is dropped, ovf_err[1]=1, count=7.
- Ch2 runs 20 write/ack pairs with bank IDs cycling 0..3, including cycles with a simultaneous write and ack: output order matches input order across 2 wraps, and count stays at 1 on simultaneous cycles.
- Ch0 holds 5 entries when flush[0] and a write occur in the same cycle: the next cycle shows kob_count[0]=0, kob_empty[0]=1, d_rob_req[0]=0, and ch1/ch2 are unaffected.
- A store (is_load=0) handshake on ch1 creates no entry. rst pulsed mid-stream with 4 entries held: all outputs return to reset values without waiting for a clock edge.
